// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of dmem_arbiter: two request/response channels.
// master = requester view, slave = arbiter view.
interface dmem_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [0:31] req0_addr;
  logic [31:0] req0_wdata;
  logic [2:0]  req0_memread;
  logic [1:0]  req0_memwrite;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        rsp0_err;

  logic        req1_valid;
  logic        req1_ready;
  logic [0:31] req1_addr;
  logic [31:0] req1_wdata;
  logic [2:0]  req1_memread;
  logic [1:0]  req1_memwrite;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic        rsp1_err;

  modport master (
    output req0_valid, req0_addr, req0_wdata, req0_memread, req0_memwrite,
    output req1_valid, req1_addr, req1_wdata, req1_memread, req1_memwrite,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err
  );

  modport slave (
    input  req0_valid, req0_addr, req0_wdata, req0_memread, req0_memwrite,
    input  req1_valid, req1_addr, req1_wdata, req1_memread, req1_memwrite,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single data memory port.
// Optional macro DMEM_ALIGN_CHECK_EN rejects word-misaligned addresses.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     bus,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_writedata,
  output logic [2:0]        mem_MemRead,
  output logic [1:0]        mem_MemWrite,
  input  logic [31:0]       mem_data,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]  state;
  logic        last_grant;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [2:0]  cmd_rd;
  logic [1:0]  cmd_wr;
  logic        cmd_id;
  logic        cmd_bad;

  logic        sel;
  logic        accept;
  logic [0:31] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_rd;
  logic [1:0]  sel_wr;

  // Range check is done in 33 bits so addresses near 2^32 cannot wrap into range.
  function automatic logic is_illegal(input logic [0:31] addr,
                                      input logic [2:0]  rd,
                                      input logic [1:0]  wr);
    logic        bad;
    logic [32:0] last_byte;
    last_byte = {1'b0, addr} + 33'd3;
    bad = ((rd != 3'b000) && (wr != 2'b00)) ||
          ((rd == 3'b000) && (wr == 2'b00)) ||
          (rd == 3'b001) || (rd == 3'b011) || (rd == 3'b101) ||
          (last_byte >= 33'(MEM_BYTES));
`ifdef DMEM_ALIGN_CHECK_EN
    bad = bad || (addr[30:31] != 2'b00);
`endif
    return bad;
  endfunction

  always_comb begin
    if (bus.req0_valid && bus.req1_valid) sel = ~last_grant;
    else                                  sel = ~bus.req0_valid;
    accept        = rst_n && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    bus.req0_ready = accept && !sel;
    bus.req1_ready = accept &&  sel;
    sel_addr  = sel ? bus.req1_addr     : bus.req0_addr;
    sel_wdata = sel ? bus.req1_wdata    : bus.req0_wdata;
    sel_rd    = sel ? bus.req1_memread  : bus.req0_memread;
    sel_wr    = sel ? bus.req1_memwrite : bus.req0_memwrite;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cmd_rd     <= '0;
      cmd_wr     <= '0;
      cmd_id     <= 1'b0;
      cmd_bad    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_addr   <= sel_addr;
            cmd_wdata  <= sel_wdata;
            cmd_rd     <= sel_rd;
            cmd_wr     <= sel_wr;
            cmd_id     <= sel;
            cmd_bad    <= is_illegal(sel_addr, sel_rd, sel_wr);
            last_grant <= sel;
            state      <= ISSUE;
          end
        end
        ISSUE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_address    = '0;
    mem_writedata  = '0;
    mem_MemRead    = '0;
    mem_MemWrite   = '0;
    bus.rsp0_valid = 1'b0;
    bus.rsp0_err   = 1'b0;
    bus.rsp0_rdata = '0;
    bus.rsp1_valid = 1'b0;
    bus.rsp1_err   = 1'b0;
    bus.rsp1_rdata = '0;
    busy           = (state != IDLE);
    if (state == ISSUE) begin
      mem_address   = cmd_addr;
      mem_writedata = cmd_wdata;
      if (!cmd_bad) begin
        mem_MemRead  = cmd_rd;
        mem_MemWrite = cmd_wr;
      end
    end else if (state == RESP) begin
      if (cmd_id) begin
        bus.rsp1_valid = 1'b1;
        bus.rsp1_err   = cmd_bad;
        bus.rsp1_rdata = (!cmd_bad && cmd_rd != 3'b000) ? mem_data : '0;
      end else begin
        bus.rsp0_valid = 1'b1;
        bus.rsp0_err   = cmd_bad;
        bus.rsp0_rdata = (!cmd_bad && cmd_rd != 3'b000) ? mem_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a word-wide synchronous memory model.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic [2:0]  mem_MemRead;
  logic [1:0]  mem_MemWrite;
  logic [31:0] mem_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:511];

  dmem_arbiter_if bus();

  dmem_arbiter #(.MEM_BYTES(2048)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_MemRead  (mem_MemRead),
    .mem_MemWrite (mem_MemWrite),
    .mem_data     (mem_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_MemWrite != 2'b00) mem[mem_address[10:2]] <= mem_writedata;
    mem_data <= mem[mem_address[10:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic [2:0] rd,
                         input logic [1:0] wr, input logic [31:0] addr, input logic [31:0] wd);
    if (k == 0) begin
      bus.req0_valid = v; bus.req0_memread = rd; bus.req0_memwrite = wr;
      bus.req0_addr = addr; bus.req0_wdata = wd;
    end else begin
      bus.req1_valid = v; bus.req1_memread = rd; bus.req1_memwrite = wr;
      bus.req1_addr = addr; bus.req1_wdata = wd;
    end
  endtask

  // One isolated transaction on requester k, checked cycle by cycle.
  task automatic run_one(input int k, input logic [2:0] rd, input logic [1:0] wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rdata);
    @(negedge clk);
    set_req(k, 1'b1, rd, wr, addr, wd);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rsp", 32'(k == 0 ? bus.rsp0_valid : bus.rsp1_valid), 32'd0);
    chk("ready_win", 32'(k == 0 ? bus.req0_ready : bus.req1_ready), 32'd1);
    chk("ready_lose", 32'(k == 0 ? bus.req1_ready : bus.req0_ready), 32'd0);
    @(negedge clk);
    set_req(k, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    #1;
    chk("issue_busy", 32'(busy), 32'd1);
    chk("issue_rd", 32'(mem_MemRead), exp_err ? 32'd0 : 32'(rd));
    chk("issue_wr", 32'(mem_MemWrite), exp_err ? 32'd0 : 32'(wr));
    if (!exp_err) begin
      chk("issue_addr", mem_address, addr);
      chk("issue_wdata", mem_writedata, wd);
    end
    @(negedge clk);
    #1;
    chk("rsp_valid", 32'(k == 0 ? bus.rsp0_valid : bus.rsp1_valid), 32'd1);
    chk("rsp_other", 32'(k == 0 ? bus.rsp1_valid : bus.rsp0_valid), 32'd0);
    chk("rsp_err", 32'(k == 0 ? bus.rsp0_err : bus.rsp1_err), 32'(exp_err));
    chk("rsp_rdata", k == 0 ? bus.rsp0_rdata : bus.rsp1_rdata, exp_rdata);
    chk("rsp_strobe", 32'(mem_MemRead) | 32'(mem_MemWrite), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[4]   = 32'hDEADBEEF;
    mem[511] = 32'hCAFEF00D;
    rst_n = 1'b0;
    set_req(0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    set_req(1, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp0", 32'(bus.rsp0_valid), 32'd0);
    chk("rst_rsp1", 32'(bus.rsp1_valid), 32'd0);
    chk("rst_err0", 32'(bus.rsp0_err), 32'd0);
    chk("rst_rdata0", bus.rsp0_rdata, 32'd0);
    chk("rst_memrd", 32'(mem_MemRead), 32'd0);
    chk("rst_memwr", 32'(mem_MemWrite), 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_wdata", mem_writedata, 32'd0);
    set_req(0, 1'b1, 3'b110, 2'b00, 32'h10, 32'h0);
    #1;
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    set_req(0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // lw from 0x10 returns the preloaded word two cycles after acceptance
    run_one(0, 3'b110, 2'b00, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Simultaneous stores out of reset: req0 first, req1 accepted three cycles later
    @(negedge clk);
    set_req(0, 1'b1, 3'b000, 2'b11, 32'h20, 32'h11111111);
    set_req(1, 1'b1, 3'b000, 2'b11, 32'h24, 32'h22222222);
    #1;
    chk("tie_ready0", 32'(bus.req0_ready), 32'd1);
    chk("tie_ready1", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    set_req(0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    #1;
    chk("tie_wr_a", 32'(mem_MemWrite), 32'd3);
    chk("tie_addr_a", mem_address, 32'h20);
    chk("tie_wdata_a", mem_writedata, 32'h11111111);
    chk("tie_hold1_a", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("tie_rsp0", 32'(bus.rsp0_valid), 32'd1);
    chk("tie_rsp0_err", 32'(bus.rsp0_err), 32'd0);
    chk("tie_rsp0_rdata", bus.rsp0_rdata, 32'd0);
    chk("tie_rsp1_early", 32'(bus.rsp1_valid), 32'd0);
    chk("tie_hold1_b", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("tie_ready1_c3", 32'(bus.req1_ready), 32'd1);
    chk("tie_ready0_c3", 32'(bus.req0_ready), 32'd0);
    @(negedge clk);
    set_req(1, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    #1;
    chk("tie_wr_b", 32'(mem_MemWrite), 32'd3);
    chk("tie_addr_b", mem_address, 32'h24);
    chk("tie_wdata_b", mem_writedata, 32'h22222222);
    @(negedge clk);
    #1;
    chk("tie_rsp1", 32'(bus.rsp1_valid), 32'd1);
    chk("tie_rsp1_err", 32'(bus.rsp1_err), 32'd0);
    chk("tie_rsp0_late", 32'(bus.rsp0_valid), 32'd0);

    run_one(1, 3'b110, 2'b01, 32'h10, 32'h0, 1'b1, 32'h0);          // read+write together
    run_one(0, 3'b100, 2'b00, 32'd2045, 32'h0, 1'b1, 32'h0);        // past end of memory
    run_one(0, 3'b100, 2'b00, 32'd2044, 32'h0, 1'b0, 32'hCAFEF00D); // last legal word
`ifdef DMEM_ALIGN_CHECK_EN
    run_one(0, 3'b000, 2'b10, 32'h22, 32'h00001234, 1'b1, 32'h0);
`else
    run_one(0, 3'b000, 2'b10, 32'h22, 32'h00001234, 1'b0, 32'h0);
`endif
    run_one(1, 3'b000, 2'b00, 32'h30, 32'h0, 1'b1, 32'h0);          // no operation
    run_one(1, 3'b101, 2'b00, 32'h30, 32'h0, 1'b1, 32'h0);          // reserved read code
    run_one(1, 3'b111, 2'b00, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);   // lui counts as a load
    run_one(1, 3'b000, 2'b11, 32'hFFFFFFFE, 32'h5, 1'b1, 32'h0);    // would wrap in 32 bits

    // Reset during ISSUE aborts the load and restores req0 priority
    @(negedge clk);
    set_req(0, 1'b1, 3'b110, 2'b00, 32'h10, 32'h0);
    #1;
    chk("ab_ready0", 32'(bus.req0_ready), 32'd1);
    @(negedge clk);
    set_req(0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    #1;
    chk("ab_issue_rd", 32'(mem_MemRead), 32'd6);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_rsp0", 32'(bus.rsp0_valid), 32'd0);
    chk("ab_rsp1", 32'(bus.rsp1_valid), 32'd0);
    chk("ab_memrd", 32'(mem_MemRead), 32'd0);
    rst_n = 1'b1;
    set_req(0, 1'b1, 3'b110, 2'b00, 32'h10, 32'h0);
    set_req(1, 1'b1, 3'b100, 2'b00, 32'd2044, 32'h0);
    #1;
    chk("ab_tie_ready0", 32'(bus.req0_ready), 32'd1);
    chk("ab_tie_ready1", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    set_req(0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    #1;
    chk("ab_addr0", mem_address, 32'h10);
    @(negedge clk);
    #1;
    chk("ab_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    chk("ab_rsp0_rdata", bus.rsp0_rdata, 32'hDEADBEEF);
    @(negedge clk);
    #1;
    chk("ab_ready1", 32'(bus.req1_ready), 32'd1);
    @(negedge clk);
    set_req(1, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    #1;
    chk("ab_rd1", 32'(mem_MemRead), 32'd4);
    chk("ab_addr1", mem_address, 32'd2044);
    @(negedge clk);
    #1;
    chk("ab_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    chk("ab_rsp1_rdata", bus.rsp1_rdata, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter: MEM_BYTES, 2048, data memory size in bytes; range check bound.
REQ-002 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have, per requester k in {0,1}: reqk_valid  in  1  request present.
REQ-005 SHALL have reqk_ready  out  1  request accepted this cycle.
REQ-006 SHALL have reqk_addr  in  32  byte address, [0:31] msb-first numbering.
REQ-007 SHALL have reqk_wdata  in  32  store data.
REQ-008 SHALL have reqk_memread  in  3  110 lw, 100 lb, 010 lh, 111 lui, 000 none.
REQ-009 SHALL have reqk_memwrite  in  2  11 sw, 10 sh, 01 sb, 00 none.
REQ-010 SHALL have rspk_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have rspk_rdata  out  32  load data; 0 for stores and errors.
REQ-012 SHALL have rspk_err  out  1  request rejected, qualified by rspk_valid.
REQ-013 SHALL have memory side: mem_address  out  32, mem_writedata  out  32, mem_MemRead  out  3, mem_MemWrite  out  2, mem_data  in  32.
REQ-014 SHALL have busy  out  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE; ISSUE and RESP each last exactly one cycle.
REQ-016 In IDLE, reqk_ready SHALL be combinationally high for the arbitration winner only; a request with valid&ready latches addr/wdata/opcodes and moves to ISSUE.
REQ-017 Arbitration SHALL be round-robin: one valid wins; both valid -> the one not granted last; last_grant updates on acceptance.
REQ-018 Both ready outputs SHALL be 0 in ISSUE and RESP; requesters hold valid and payload until ready.
REQ-019 In ISSUE, mem_* SHALL drive the latched command; outside ISSUE mem_MemRead=000, mem_MemWrite=00, mem_address=0, mem_writedata=0.
REQ-020 In RESP, rspk_valid SHALL pulse for the granted requester only; rspk_rdata=mem_data for legal loads, 0 otherwise.
REQ-021 Latency: accept at cycle N, memory access N+1, rsp_valid N+2, next accept no earlier than N+3.
REQ-022 A command SHALL be illegal if: memread and memwrite both nonzero; both zero; memread in {001,011,101}; or reqk_addr+3 >= MEM_BYTES (computed 33-bit, no wrap).
REQ-023 Illegal command SHALL still go ISSUE -> RESP with mem_MemRead=000, mem_MemWrite=00 in ISSUE, and rsp_err=1, rdata=0 in RESP.
REQ-024 Legal stores SHALL complete with rsp_valid=1, rsp_err=0, rdata=0.
REQ-025 Requests arriving while busy SHALL not be lost or reordered per requester; they wait for ready.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, last_grant=1 (req0 wins first tie), latched command=0.
REQ-027 During and after reset all outputs SHALL be 0 (ready, rsp_valid, rsp_err, rdata, busy, mem_*).
REQ-028 Reset in ISSUE or RESP SHALL abort: no rsp_valid delivered for the aborted request; a memory write already driven in ISSUE is not undone.

Configuration
REQ-029 Macro DMEM_ALIGN_CHECK_EN defined: a command with reqk_addr[30:31]!=00 SHALL additionally be illegal per REQ-023.
REQ-030 Macro undefined: no alignment check; misaligned addresses pass to memory unchanged.

Verification
REQ-031 req0 lw addr=0x10 alone, memory word 0xDEADBEEF -> ready0 cycle 0, mem_MemRead=110 addr 0x10 cycle 1, rsp0_valid with rdata 0xDEADBEEF cycle 2.
REQ-032 req0 and req1 valid together out of reset, both sw -> req0 granted first, req1 accepted cycle 3, mem_MemWrite=11 in cycles 1 and 4.
REQ-033 req1 memread=110 and memwrite=01 -> no memory strobe in ISSUE, rsp1_valid with rsp1_err=1, rdata=0.
REQ-034 req0 lb addr=2045 (MEM_BYTES=2048) -> rsp0_err=1; addr=2044 -> rsp0_err=0.
REQ-035 With DMEM_ALIGN_CHECK_EN, sh addr=0x22 -> rsp_err=1 and no write; without macro -> mem_MemWrite=10 addr 0x22, rsp_err=0.
REQ-036 rst_n low during ISSUE of a lw -> next cycle busy=0, no rsp_valid; first post-reset tie goes to req0.
